// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, mux-select codes and the decoded instruction class.
package mc_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  localparam logic [2:0] NPC_PC4   = 3'b000;
  localparam logic [2:0] NPC_BEQ   = 3'b001;
  localparam logic [2:0] NPC_JAL   = 3'b010;
  localparam logic [2:0] NPC_JR    = 3'b011;
  localparam logic [2:0] NPC_BGEZ  = 3'b100;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MDR   = 2'b01;
  localparam logic [1:0] M2R_LUI   = 2'b10;
  localparam logic [1:0] M2R_PC    = 2'b11;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_BYTE  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic load;
    logic store;
    logic lui;
    logic beq;
    logic bgez;
    logic jal;
    logic jr;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct -> one-hot class plus the
// ALU-side fields used while the instruction is in EXEC.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic       alu_src_o,
  output logic [1:0] alu_ctr_o,
  output logic [1:0] ext_op_o
);

  always_comb begin
    cls_o     = '0;
    alu_src_o = 1'b0;
    alu_ctr_o = ALU_ADD;
    ext_op_o  = EXT_SIGN;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU) begin
          cls_o.rtype_alu = 1'b1;
        end else if (funct_i == FN_SUBU) begin
          cls_o.rtype_alu = 1'b1;
          alu_ctr_o       = ALU_SUB;
        end else if (funct_i == FN_JR) begin
          cls_o.jr = 1'b1;
        end else begin
          cls_o.illegal = 1'b1;  // includes nop (sll $0,$0,0)
        end
      end
      OP_ORI: begin
        cls_o.ori = 1'b1;
        alu_src_o = 1'b1;
        alu_ctr_o = ALU_OR;
        ext_op_o  = EXT_ZERO;
      end
      OP_LW: begin
        cls_o.load = 1'b1;
        alu_src_o  = 1'b1;
      end
      OP_LBU: begin
        cls_o.load = 1'b1;
        alu_src_o  = 1'b1;
        ext_op_o   = EXT_BYTE;
      end
      OP_SW: begin
        cls_o.store = 1'b1;
        alu_src_o   = 1'b1;
      end
      OP_LUI:    cls_o.lui  = 1'b1;
      OP_BEQ:    cls_o.beq  = 1'b1;
      OP_REGIMM: cls_o.bgez = 1'b1;
      OP_JAL:    cls_o.jal  = 1'b1;
      default:   cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// data-memory ready handshake, bounded MEM wait and sticky timeout flag.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        GEZ,
  input  logic        dm_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  MemtoReg,
  output logic [2:0]  nPC_sel,
  output logic [1:0]  ExtOP,
  output logic [1:0]  ALUctr,
  output logic [2:0]  state,
  output logic        done,
  output logic        err
);

  localparam logic            TO_EN   = (MEM_TIMEOUT != 0);
  // Timeout fires in the MEM cycle whose increment would reach MEM_TIMEOUT,
  // so the request is held for exactly MEM_TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  iclass_t    cls;
  logic       dec_alu_src;
  logic [1:0] dec_alu_ctr;
  logic [1:0] dec_ext_op;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[25:21], Instr[15:6]};

  mc_decode u_dec (
    .op_i      (Instr[31:26]),
    .funct_i   (Instr[5:0]),
    .cls_o     (cls),
    .alu_src_o (dec_alu_src),
    .alu_ctr_o (dec_alu_ctr),
    .ext_op_o  (dec_ext_op)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    RegDst   = DST_RT;
    ALUSrc   = 1'b0;
    MemtoReg = M2R_ALU;
    nPC_sel  = NPC_PC4;
    ExtOP    = EXT_SIGN;
    ALUctr   = ALU_ADD;
    done     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        nPC_sel = NPC_PC4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls.illegal) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSrc  = dec_alu_src;
        ALUctr  = dec_alu_ctr;
        ExtOP   = dec_ext_op;
        state_d = S_FETCH;
        if (cls.rtype_alu || cls.ori || cls.lui) state_d = S_WB;
        if (cls.load || cls.store)               state_d = S_MEM;
        if (cls.beq) begin
          PCWrite = Zero;
          nPC_sel = NPC_BEQ;
          done    = 1'b1;
        end
        if (cls.bgez) begin
          PCWrite = (Instr[20:16] == 5'd1) && GEZ;
          nPC_sel = NPC_BGEZ;
          done    = 1'b1;
        end
        if (cls.jr) begin
          PCWrite = 1'b1;
          nPC_sel = NPC_JR;
          done    = 1'b1;
        end
        if (cls.jal) begin
          PCWrite  = 1'b1;
          nPC_sel  = NPC_JAL;
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemtoReg = M2R_PC;
          done     = 1'b1;
        end
      end
      S_MEM: begin
        MemRead  = cls.load;
        MemWrite = cls.store;
        if (dm_ready) begin
          cnt_d = '0;
          if (cls.load) begin
            state_d = S_WB;
          end else begin
            done    = 1'b1;
            state_d = S_FETCH;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          done    = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        done     = 1'b1;
        state_d  = S_FETCH;
        if (cls.rtype_alu) RegDst   = DST_RD;
        if (cls.load)      MemtoReg = M2R_MDR;
        if (cls.lui)       MemtoReg = M2R_LUI;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset quiets every enable and select combinationally, aborting any DM access.
    if (!reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      RegDst   = '0;
      ALUSrc   = 1'b0;
      MemtoReg = '0;
      nPC_sel  = '0;
      ExtOP    = '0;
      ALUctr   = '0;
      done     = 1'b0;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed vector table, a mid-MEM reset sequence and
// random instructions, all checked cycle by cycle against a trace model.
module tb_mc_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero, GEZ, dm_ready;
  logic        IRWrite, PCWrite, RegWrite, MemWrite, MemRead, ALUSrc, done, err;
  logic [1:0]  RegDst, MemtoReg, ExtOP, ALUctr;
  logic [2:0]  nPC_sel, state;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .GEZ(GEZ),
    .dm_ready(dm_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .nPC_sel(nPC_sel),
    .ExtOP(ExtOP), .ALUctr(ALUctr), .state(state), .done(done), .err(err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       irw, pcw, rw, mw, mr;
    logic [1:0] rd;
    logic       as;
    logic [1:0] m2r;
    logic [2:0] npc;
    logic [1:0] ext;
    logic [1:0] alu;
    logic       dn;
    logic       err;
  } rec_t;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        z, g;
    int          w;
    int          lat;
    logic        err_after;
  } vec_t;

  rec_t eq[$];
  logic rq[$];
  logic err_m = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic rec_t sample();
    rec_t r;
    r.st = state; r.irw = IRWrite; r.pcw = PCWrite; r.rw = RegWrite;
    r.mw = MemWrite; r.mr = MemRead; r.rd = RegDst; r.as = ALUSrc;
    r.m2r = MemtoReg; r.npc = nPC_sel; r.ext = ExtOP; r.alu = ALUctr;
    r.dn = done; r.err = err;
    return r;
  endfunction

  function automatic void chk(string nm, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endfunction

  function automatic void chk_rec(string nm, int cyc, rec_t got, rec_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got st=%0d irw%b pcw%b rw%b mw%b mr%b rd%b as%b m2r%b npc%b ext%b alu%b dn%b err%b, required st=%0d irw%b pcw%b rw%b mw%b mr%b rd%b as%b m2r%b npc%b ext%b alu%b dn%b err%b",
               nm, cyc, got.st, got.irw, got.pcw, got.rw, got.mw, got.mr, got.rd, got.as, got.m2r, got.npc, got.ext, got.alu, got.dn, got.err,
               exp.st, exp.irw, exp.pcw, exp.rw, exp.mw, exp.mr, exp.rd, exp.as, exp.m2r, exp.npc, exp.ext, exp.alu, exp.dn, exp.err);
    end
  endfunction

  function automatic void push(rec_t e, logic rdy);
    eq.push_back(e);
    rq.push_back(rdy);
  endfunction

  // Expected per-cycle trace of one instruction from the instruction-level rules.
  // w = number of MEM cycles without dm_ready before it arrives (>= TMO: never).
  task automatic build(input logic [31:0] ins, input logic z, input logic g, input int w);
    rec_t e;
    logic [5:0] op, fn;
    bit r_alu, is_jr, is_ori, is_ld, is_st, is_lui, is_br, ok;
    int n;
    op = ins[31:26]; fn = ins[5:0];
    r_alu  = (op == 6'h00) && (fn == 6'h21 || fn == 6'h23);
    is_jr  = (op == 6'h00) && (fn == 6'h08);
    is_ori = (op == 6'h0d);
    is_ld  = (op == 6'h23) || (op == 6'h24);
    is_st  = (op == 6'h2b);
    is_lui = (op == 6'h0f);
    is_br  = (op == 6'h04) || (op == 6'h01) || (op == 6'h03);
    ok     = r_alu | is_jr | is_ori | is_ld | is_st | is_lui | is_br;
    eq.delete(); rq.delete();
    e = '0; e.st = 3'd0; e.irw = 1; e.pcw = 1; e.err = err_m;
    push(e, 1'($urandom_range(0, 1)));
    e = '0; e.st = 3'd1; e.err = err_m; e.dn = !ok;
    push(e, 1'($urandom_range(0, 1)));
    if (!ok) return;
    e = '0; e.st = 3'd2; e.err = err_m;
    case (op)
      6'h00: if (fn == 6'h23) e.alu = 2'b01;
      6'h0d: begin e.as = 1; e.alu = 2'b10; e.ext = 2'b01; end
      6'h23, 6'h2b: e.as = 1;
      6'h24: begin e.as = 1; e.ext = 2'b10; end
      6'h04: begin e.pcw = z; e.npc = 3'b001; e.dn = 1; end
      6'h01: begin e.pcw = (ins[20:16] == 5'd1) && g; e.npc = 3'b100; e.dn = 1; end
      6'h03: begin e.pcw = 1; e.npc = 3'b010; e.rw = 1; e.rd = 2'b10; e.m2r = 2'b11; e.dn = 1; end
      default: ;
    endcase
    if (is_jr) begin e.pcw = 1; e.npc = 3'b011; e.dn = 1; end
    push(e, 1'($urandom_range(0, 1)));
    if (is_ld || is_st) begin
      n = (w >= TMO) ? TMO : w + 1;
      for (int k = 0; k < n; k++) begin
        e = '0; e.st = 3'd3; e.err = err_m; e.mr = is_ld; e.mw = is_st;
        e.dn = (k == n - 1) && (w >= TMO || is_st);
        push(e, (w < TMO) && (k == w));
      end
      if (w >= TMO) begin
        err_m = 1'b1;
        return;
      end
    end
    if (r_alu || is_ori || is_ld || is_lui) begin
      e = '0; e.st = 3'd4; e.rw = 1; e.dn = 1; e.err = err_m;
      if (r_alu)  e.rd  = 2'b01;
      if (is_ld)  e.m2r = 2'b01;
      if (is_lui) e.m2r = 2'b10;
      push(e, 1'($urandom_range(0, 1)));
    end
  endtask

  // Entered and left at #1 after a rising edge, with the DUT in FETCH.
  task automatic run(input string nm, input logic [31:0] ins, input logic z,
                     input logic g, input int w, output int lat);
    rec_t got;
    build(ins, z, g, w);
    lat = -1;
    for (int i = 0; i < eq.size(); i++) begin
      Instr = ins; Zero = z; GEZ = g; dm_ready = rq[i];
      @(negedge clk);
      got = sample();
      chk_rec(nm, i, got, eq[i]);
      if (got.dn && lat < 0) lat = i + 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    err_m = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] ins;
    logic [5:0]  ops[12];
    logic [5:0]  fns[5];
    int w;

    vecs.push_back('{"addu",     32'h00221821, 0, 0, 0,  4, 0});
    vecs.push_back('{"subu",     32'h00222023, 0, 0, 0,  4, 0});
    vecs.push_back('{"ori",      32'h342500ff, 0, 0, 0,  4, 0});
    vecs.push_back('{"lui",      32'h3c061234, 0, 0, 0,  4, 0});
    vecs.push_back('{"lw_w2",    32'h8c270004, 0, 0, 2,  7, 0});
    vecs.push_back('{"lbu",      32'h90280001, 0, 0, 0,  5, 0});
    vecs.push_back('{"sw_w1",    32'hac270008, 0, 0, 1,  5, 0});
    vecs.push_back('{"beq_z1",   32'h10220003, 1, 0, 0,  3, 0});
    vecs.push_back('{"beq_z0",   32'h10220003, 0, 1, 0,  3, 0});
    vecs.push_back('{"bgez_rt1", 32'h04210005, 0, 1, 0,  3, 0});
    vecs.push_back('{"bgez_rt0", 32'h04200005, 0, 1, 0,  3, 0});
    vecs.push_back('{"jal",      32'h0c000010, 0, 0, 0,  3, 0});
    vecs.push_back('{"jr",       32'h03e00008, 0, 0, 0,  3, 0});
    vecs.push_back('{"nop",      32'h00000000, 0, 0, 0,  2, 0});
    vecs.push_back('{"bad_op",   32'hfc000000, 0, 0, 0,  2, 0});
    vecs.push_back('{"sw_tmo",   32'hac270008, 0, 0, 99, 18, 1});
    vecs.push_back('{"lw_tmo",   32'h8c270004, 0, 0, 99, 18, 1});

    reset = 1'b0; Instr = 32'h00221821; Zero = 0; GEZ = 0; dm_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_rec("reset_state", 0, sample(), rec_t'('0));
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].nm, vecs[i].ins, vecs[i].z, vecs[i].g, vecs[i].w, lat);
      chk({vecs[i].nm, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].nm, "_err"}, int'(err), int'(vecs[i].err_after));
    end

    // sw stalls in MEM with err already set; reset lands in the third MEM cycle.
    Instr = 32'hac270008; dm_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk("hs_mem_state", int'(state), 3);
        chk("hs_mem_memwrite", int'(MemWrite), 1);
        chk("hs_mem_err_sticky", int'(err), 1);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("hs_rst_memwrite", int'(MemWrite), 0);
    chk("hs_rst_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("hs_post_state", int'(state), 0);
    chk("hs_post_err", int'(err), 0);
    chk("hs_post_memwrite", int'(MemWrite), 0);
    chk("hs_post_irwrite", int'(IRWrite), 1);
    @(posedge clk); #1;
    do_reset();

    ops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h23, 6'h24, 6'h2b,
            6'h04, 6'h01, 6'h0f, 6'h03, 6'h3e};
    fns = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h2a};
    for (int t = 0; t < 120; t++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 11)];
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 4)];
      if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
      w = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      run("rand", ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, lat);
      chk("rand_latency", lat, eq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle controller FSM that sequences the existing MIPS datapath (PC/NPC, IR, GRF, EXT, ALU, DM) one step per clock. It supports the same instruction set as the single-cycle decoder: addu, subu, ori, lw, lbu, sw, beq, bgez, lui, jal, jr. It drives per-state write enables and mux selects, and runs a ready/timeout handshake with data memory. It replaces the single-cycle controller at the top level of the multi-cycle CPU.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for dm_ready; 0 disables the timeout.
TO_W, 4, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
Instr  in  32  IR output; stable from DECODE until the instruction completes
Zero  in  1  ALU equality flag (rs == rt), valid in EXEC
GEZ  in  1  rs[31] == 0, valid in EXEC
dm_ready  in  1  data memory has accepted the write or returned read data this cycle
IRWrite  out  1  load IR from IM
PCWrite  out  1  load PC from NPC
RegWrite  out  1  GRF write enable
MemWrite  out  1  DM write request, held until dm_ready
MemRead  out  1  DM read request, held until dm_ready
RegDst  out  2  00 rt, 01 rd, 10 $31
ALUSrc  out  1  0 rt, 1 ext(imm)
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 lui value, 11 PC (already +4)
nPC_sel  out  3  000 PC+4, 001 beq target, 010 jal, 011 jr, 100 bgez target
ExtOP  out  2  00 sign, 01 zero, 10 byte-zero (lbu)
ALUctr  out  2  00 add, 01 sub, 10 or
state  out  3  current state, for debug
done  out  1  high in the last cycle of each instruction
err  out  1  sticky DM timeout flag

Behaviour:
- State is registered. All other outputs are combinational from state and Instr.
- Reset (reset==0 at posedge): state <= FETCH, wait counter <= 0, err <= 0.
- While reset is low, all enables (IRWrite, PCWrite, RegWrite, MemWrite, MemRead, done) are forced to 0 and all selects to 0.
- Reset mid-MEM aborts the access; no write-back occurs.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH: IRWrite=1, PCWrite=1, nPC_sel=000. Next state is DECODE.
- DECODE: no enables. A recognised instruction goes to EXEC. An undefined opcode or funct (including nop) asserts done and returns to FETCH, so it takes 2 cycles.
- EXEC:
  - addu, subu, ori, lw, lbu, sw: ALUSrc, ALUctr and ExtOP are held as in the single-cycle table. addu, subu and ori go to WB; the loads and sw go to MEM.
  - lui: goes to WB.
  - beq: PCWrite = Zero, nPC_sel=001, done=1, next FETCH.
  - bgez: PCWrite = (Instr[20:16]==1 && GEZ), nPC_sel=100, done=1, next FETCH. When rt != 1 it behaves as a nop.
  - jr: PCWrite=1, nPC_sel=011, done=1, next FETCH.
  - jal: PCWrite=1, nPC_sel=010, RegWrite=1, RegDst=10, MemtoReg=11 in the same cycle, done=1, next FETCH.
- MEM:
  - MemRead (lw/lbu) or MemWrite (sw) is held every cycle until dm_ready.
  - On dm_ready: loads go to WB; sw asserts done and goes to FETCH.
  - The wait counter increments each cycle without dm_ready. If it equals MEM_TIMEOUT (and MEM_TIMEOUT != 0), err <= 1, done=1, state <= FETCH, and the request drops.
  - The counter clears on leaving MEM.
- WB: RegWrite=1, done=1, next FETCH.
  - addu/subu: RegDst=01, MemtoReg=00.
  - ori: RegDst=00, MemtoReg=00.
  - lw/lbu: RegDst=00, MemtoReg=01.
  - lui: RegDst=00, MemtoReg=10.
- Latency with zero-wait DM:
  - addu, subu, ori, lui: 4 cycles.
  - lw, lbu: 5 cycles, plus wait cycles.
  - sw: 4 cycles, plus wait cycles.
  - beq, bgez, jr, jal: 3 cycles.
- dm_ready is ignored outside MEM.
- Enables are never asserted in a state not listed above.

Decomposition:
- Package mc_defs: opcode and funct constants, state encodings, nPC_sel/MemtoReg/RegDst/ExtOP/ALUctr encodings.
- Sub-module mc_decode: combinational Instr -> one-hot instruction class (rtype_alu, ori, load, store, lui, beq, bgez, jal, jr, illegal) plus the ALUctr/ExtOP fields.
- mc_ctrl holds the FSM, the wait counter and the err flag.

Test Plan:
- addu $3,$1,$2 after reset, dm_ready tied 1 -> states 0,1,2,4; WB cycle shows RegWrite=1, RegDst=01, done=1; next cycle state=0.
- lw with dm_ready low for 2 MEM cycles -> MemRead high for 3 cycles, then WB with MemtoReg=01; 7 cycles total; err stays 0.
- beq with Zero=1, then with Zero=0 -> PCWrite=1/nPC_sel=001 in EXEC, then PCWrite=0 (only the FETCH PCWrite occurs); 3 cycles each.
- bgez with rt=00001 and GEZ=1 -> PCWrite=1, nPC_sel=100; with rt=00000 -> PCWrite=0, done in EXEC.
- jal -> EXEC shows PCWrite=1, nPC_sel=010, RegWrite=1, RegDst=10, MemtoReg=11, done=1.
- sw with dm_ready never asserted, MEM_TIMEOUT=15 -> MemWrite high for 15 cycles, then err=1 (sticky) and state=FETCH. A later reset=0 for 1 cycle during a subsequent MEM clears err, returns state to 0 and drops MemWrite the following cycle.
